// File: rtl/ov_stream_pkg.sv
// rtl/ov_stream_pkg.sv - shared types, pattern encodings and colour-bar table for the OV7670 stream generator
package ov_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_BACK,
        ST_ACTIVE,
        ST_FRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_t;

    localparam logic [15:0] BAR_RGB [0:7] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // The camera bus carries the high byte of each pixel first.
    function automatic logic [7:0] rgb565_byte(input logic [15:0] rgb, input logic low_byte);
        return low_byte ? rgb[7:0] : rgb[15:8];
    endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// rtl/ov7670_stream_gen_if.sv - emulated OV7670 parallel camera bus
interface ov7670_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output pclk, vsync, href, data);
    modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/ov_pattern_rgb565.sv
// rtl/ov_pattern_rgb565.sv - RGB565 test-pattern colour for one pixel, registered output
module ov_pattern_rgb565
    import ov_stream_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  pattern_t    pattern,
    input  logic [15:0] solid,
    output logic [15:0] rgb
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [9:0]  bar_idx;
    logic [15:0] rgb_d;

    always_comb begin
        bar_idx = x / 10'(BAR_W);
        rgb_d   = solid;
        case (pattern)
            PAT_BARS:     rgb_d = BAR_RGB[(bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0]];
            PAT_GRADIENT: rgb_d = {x[9:5], x[9:4], x[9:5]};
            // 32x32 squares: bit 5 of x and y selects the square parity.
            PAT_CHECKER:  rgb_d = (((x ^ y) & 10'h020) != 10'h000) ? 16'h0000 : 16'hFFFF;
            default:      rgb_d = solid;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_d;
        end
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670 camera-bus frame generator; OV_STREAM_GEN_SCROLL_EN adds per-frame horizontal scroll
module ov7670_stream_gen
    import ov_stream_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 510
) (
    input  logic                       clk25,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [15:0]                solid_rgb,
    ov7670_stream_gen_if.master        cam,
    output logic                       frame_start,
    output logic                       busy
);

    localparam int BACK_END   = V_SYNC + V_BACK;
    localparam int ACTIVE_END = V_SYNC + V_BACK + V_ACTIVE;

    logic        pclk_q;
    logic        tick;
    state_t      state_q, state_d;
    logic [9:0]  line_q, line_d;
    logic [9:0]  pix_q, pix_d;
    logic        lo_q, lo_d;
    logic        start_frame;
    pattern_t    pat_q;
    logic [15:0] solid_q;
    logic [9:0]  x_pat, y_pat;
    logic [15:0] rgb;

    logic        vsync_q, href_q, frame_start_q;
    logic [7:0]  data_q;
    logic        vsync_d, href_d, frame_start_d;
    logic [7:0]  data_d;

    // Every bus update happens on the clk25 edge where pclk falls.
    assign tick = pclk_q;

    function automatic state_t line_state(input logic [9:0] ln);
        if (ln < 10'(V_SYNC))     return ST_SYNC;
        if (ln < 10'(BACK_END))   return ST_BACK;
        if (ln < 10'(ACTIVE_END)) return ST_ACTIVE;
        return ST_FRONT;
    endfunction

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q  <= 1'b0;
            state_q <= ST_IDLE;
            line_q  <= '0;
            pix_q   <= '0;
            lo_q    <= 1'b0;
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else begin
            pclk_q <= ~pclk_q;
            if (tick) begin
                state_q <= state_d;
                line_q  <= line_d;
                pix_q   <= pix_d;
                lo_q    <= lo_d;
                if (start_frame) begin
                    pat_q   <= pattern_t'(pattern_sel);
                    solid_q <= solid_rgb;
                end
            end
        end
    end

    // Computes the byte position that the next tick will put on the bus.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        pix_d       = pix_q;
        lo_d        = lo_q;
        start_frame = 1'b0;
        if (state_q == ST_IDLE) begin
            line_d = '0;
            pix_d  = '0;
            lo_d   = 1'b0;
            if (enable) begin
                state_d     = ST_SYNC;
                start_frame = 1'b1;
            end
        end else begin
            lo_d = ~lo_q;
            if (lo_q) begin
                if (pix_q == 10'(H_TOTAL - 1)) begin
                    pix_d  = '0;
                    line_d = (line_q == 10'(V_TOTAL - 1)) ? 10'd0 : line_q + 10'd1;
                end else begin
                    pix_d = pix_q + 10'd1;
                end
            end
            if (lo_q && pix_q == 10'(H_TOTAL - 1) && line_q == 10'(V_TOTAL - 1)) begin
                state_d     = enable ? ST_SYNC : ST_IDLE;
                start_frame = enable;
            end else begin
                state_d = line_state(line_d);
            end
        end
    end

`ifdef OV_STREAM_GEN_SCROLL_EN
    logic [7:0]  scroll_q;
    logic [10:0] x_sum;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            scroll_q <= '0;
        end else if (tick && start_frame) begin
            scroll_q <= scroll_q + 8'd1;
        end
    end

    always_comb begin
        x_sum = {1'b0, pix_d} + {3'b000, scroll_q};
        x_pat = 10'(x_sum % 11'(H_ACTIVE));
    end
`else
    assign x_pat = pix_d;
`endif

    assign y_pat = line_d - 10'(BACK_END);

    // Fed with the upcoming position so its registered colour is ready one cycle before the tick.
    ov_pattern_rgb565 #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .x       (x_pat),
        .y       (y_pat),
        .pattern (pat_q),
        .solid   (solid_q),
        .rgb     (rgb)
    );

    always_comb begin
        vsync_d       = (state_d == ST_SYNC);
        href_d        = (state_d == ST_ACTIVE) && (pix_d < 10'(H_ACTIVE));
        data_d        = href_d ? rgb565_byte(rgb, lo_d) : 8'h00;
        frame_start_d = tick && start_frame;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            if (tick) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
            end
        end
    end

    assign cam.pclk    = pclk_q;
    assign cam.vsync   = vsync_q;
    assign cam.href    = href_q;
    assign cam.data    = data_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - self-checking bench for ov7670_stream_gen on a reduced frame geometry
module tb_ov7670_stream_gen;

    localparam int HA = 64, HT = 70, VS = 2, VB = 2, VA = 6, VT = 12;
    localparam int K_FRAME = VT * 2 * HT;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb;
    logic        frame_start;
    logic        busy;

    ov7670_stream_gen_if cam_if ();

    ov7670_stream_gen #(
        .H_ACTIVE (HA), .H_TOTAL (HT), .V_SYNC (VS),
        .V_BACK   (VB), .V_ACTIVE (VA), .V_TOTAL (VT)
    ) dut (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .cam         (cam_if),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk25 = ~clk25;

    int n_checks = 0;
    int n_err    = 0;

    int          n_cyc = 0, k = 0, m_pat = 0;
    bit          m_active = 0, m_fs = 0;
    logic [15:0] m_solid = '0;

    int   tg = 0, fs_cnt = 0, rel_t = 0;
    int   fs_time [0:15];
    int   vs_rise_cnt = 0, vs_rise_t = 0, vs_len_last = 0;
    int   first_href_delay = 0, href_in_frame = 0, last_frame_hrefs = 0;
    int   hr_rise_t = 0, href_len_last = 0, bidx = 0, busy_fall_t = 0;
    bit   blank_nz = 0, blank_nz_last = 0;
    logic vs_q = 0, hr_q = 0, busy_q = 0;
    logic [7:0] line0 [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_rgb(input int pat, input int x, input int y, input logic [15:0] s);
        int r, g;
        case (pat)
            0: case (x / (HA / 8))
                   0: return 16'hFFFF;
                   1: return 16'hFFE0;
                   2: return 16'h07FF;
                   3: return 16'h07E0;
                   4: return 16'hF81F;
                   5: return 16'hF800;
                   6: return 16'h001F;
                   default: return 16'h0000;
               endcase
            1: begin
                r = (x >> 5) & 31;
                g = (x >> 4) & 63;
                return 16'((r << 11) | (g << 5) | r);
            end
            2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'h0000 : 16'hFFFF;
            default: return s;
        endcase
    endfunction

    initial forever begin
        @(posedge clk25);
        tg++;
    end

    // Reference: one byte per two clk25 cycles, frames of K_FRAME bytes started by ticks with enable.
    initial forever begin
        @(posedge clk25);
        m_fs = 1'b0;
        if (rst_n !== 1'b1) begin
            n_cyc = 0; m_active = 0; k = 0;
        end else begin
            n_cyc++;
            if (n_cyc % 2 == 0) begin
                if (!m_active) begin
                    if (enable) begin
                        m_active = 1; k = 0; m_pat = pattern_sel; m_solid = solid_rgb; m_fs = 1;
                    end
                end else begin
                    k++;
                    if (k == K_FRAME) begin
                        k = 0;
                        if (enable) begin
                            m_pat = pattern_sel; m_solid = solid_rgb; m_fs = 1;
                        end else begin
                            m_active = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        int line, q, pix, lo;
        logic ev, eh, eb;
        logic [7:0]  ed;
        logic [15:0] rgb;
        forever begin
            @(negedge clk25);
            if (rst_n === 1'b1) begin
                ev = 0; eh = 0; ed = 8'h00; eb = m_active;
                if (m_active) begin
                    line = k / (2 * HT);
                    q    = k % (2 * HT);
                    pix  = q / 2;
                    lo   = q % 2;
                    ev   = (line < VS);
                    eh   = (line >= VS + VB) && (line < VS + VB + VA) && (pix < HA);
                    rgb  = m_rgb(m_pat, pix, line - VS - VB, m_solid);
                    if (eh) ed = (lo != 0) ? rgb[7:0] : rgb[15:8];
                end
                check("pclk",        cam_if.pclk,  n_cyc % 2);
                check("vsync",       cam_if.vsync, ev);
                check("href",        cam_if.href,  eh);
                check("data",        cam_if.data,  ed);
                check("frame_start", frame_start,  m_fs);
                check("busy",        busy,         eb);
            end
        end
    end

    initial forever begin
        @(negedge clk25);
        if (rst_n === 1'b1) begin
            if (frame_start) begin
                if (fs_cnt < 16) fs_time[fs_cnt] = tg;
                fs_cnt++;
                last_frame_hrefs = href_in_frame;
                href_in_frame    = 0;
                blank_nz_last    = blank_nz;
                blank_nz         = 0;
            end
            if (cam_if.vsync && !vs_q) begin vs_rise_cnt++; vs_rise_t = tg; end
            if (!cam_if.vsync && vs_q) vs_len_last = tg - vs_rise_t;
            if (cam_if.href && !hr_q) begin
                if (href_in_frame == 0) first_href_delay = tg - vs_rise_t;
                href_in_frame++;
                hr_rise_t = tg;
                bidx = 0;
            end
            if (!cam_if.href && hr_q) href_len_last = tg - hr_rise_t;
            if (cam_if.pclk && cam_if.href) begin
                if (href_in_frame == 1 && bidx < 256) line0[bidx] = cam_if.data;
                bidx++;
            end
            if (!cam_if.href && cam_if.data != 8'h00) blank_nz = 1;
            if (!busy && busy_q) busy_fall_t = tg;
        end
        vs_q = cam_if.vsync; hr_q = cam_if.href; busy_q = busy;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(negedge clk25); #1; end
    endtask

    task automatic wait_fs(input int target, input int budget);
        int c = 0;
        while (fs_cnt < target && c < budget) begin @(negedge clk25); #1; c++; end
        if (fs_cnt < target) check("frame_start_timeout", fs_cnt, target);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0; solid_rgb = 16'h0000;

        check("model_bar1",  m_rgb(0, 8, 0, 16'h0), 16'hFFE0);
        check("model_grad",  m_rgb(1, 63, 0, 16'h0), 16'h0861);
        check("model_chk",   m_rgb(2, 32, 32, 16'h0), 16'hFFFF);

        wait_cycles(5);
        check("rst_pclk", cam_if.pclk, 0);
        check("rst_vsync", cam_if.vsync, 0);
        check("rst_href", cam_if.href, 0);
        check("rst_data", cam_if.data, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_busy", busy, 0);

        rst_n = 1'b1; rel_t = tg;
        wait_fs(1, 20);
        check("first_fs_delay", fs_time[0] - rel_t, 2);

        wait_fs(2, 4000);
        check("frame_period", fs_time[1] - fs_time[0], 3360);
        check("vsync_len", vs_len_last, 560);
        check("href_delay", first_href_delay, 1120);
        check("href_len", href_len_last, 256);
        check("hrefs_per_frame", last_frame_hrefs, 6);
        check("bars_b0", line0[0], 8'hFF);
        check("bars_b1", line0[1], 8'hFF);
        check("bars_b16", line0[16], 8'hFF);
        check("bars_b17", line0[17], 8'hE0);
        check("bars_b32", line0[32], 8'h07);
        check("bars_b33", line0[33], 8'hFF);
        pattern_sel = 2'd3; solid_rgb = 16'hF81F;

        wait_fs(3, 4000);
        pattern_sel = 2'd1; solid_rgb = 16'h0000;

        wait_fs(4, 4000);
        check("solid_b0", line0[0], 8'hF8);
        check("solid_b1", line0[1], 8'h1F);
        check("solid_b126", line0[126], 8'hF8);
        check("solid_b127", line0[127], 8'h1F);
        check("blank_data_zero", blank_nz_last, 0);
        pattern_sel = 2'd2;

        wait_fs(5, 4000);
        pattern_sel = 2'd0;
        c = 0;
        while (href_in_frame < 2 && c < 2000) begin @(negedge clk25); #1; c++; end
        check("reach_active_line", href_in_frame >= 2, 1);
        enable = 1'b0;

        c = 0;
        while (busy && c < 4000) begin @(negedge clk25); #1; c++; end
        check("busy_fell", busy, 0);
        check("last_frame_len", busy_fall_t - fs_time[4], 3360);
        check("no_new_frame", fs_cnt, 5);
        wait_cycles(1000);
        check("no_vsync_after_stop", vs_rise_cnt, 5);
        check("idle_busy", busy, 0);

        enable = 1'b1;
        wait_fs(6, 20);
        wait_cycles(1700);
        @(negedge clk25);
        #3 rst_n = 1'b0;
        #1;
        check("abort_pclk", cam_if.pclk, 0);
        check("abort_vsync", cam_if.vsync, 0);
        check("abort_href", cam_if.href, 0);
        check("abort_data", cam_if.data, 0);
        check("abort_frame_start", frame_start, 0);
        check("abort_busy", busy, 0);

        wait_cycles(3);
        rst_n = 1'b1; rel_t = tg;
        wait_fs(7, 20);
        check("restart_delay", fs_time[6] - rel_t, 2);
        check("restart_vsync", cam_if.vsync, 1);
        wait_cycles(600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, 784, pixel periods per line (active plus horizontal blank).
REQ-003 SHALL have parameter V_SYNC, 3, lines with VSYNC high.
REQ-004 SHALL have parameter V_BACK, 17, blank lines after VSYNC and before the first active line.
REQ-005 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-006 SHALL have parameter V_TOTAL, 510, lines per frame.
REQ-007 SHALL have port clk25, input, 1, 25 MHz system clock.
REQ-008 SHALL have port rst_n, input, 1; reset rst_n, asynchronous, active-low; clock clk25.
REQ-009 SHALL have port enable, input, 1, level request to stream frames.
REQ-010 SHALL have port pattern_sel, input, 2: 0 colour bars, 1 horizontal gradient, 2 checkerboard, 3 solid.
REQ-011 SHALL have port solid_rgb, input, 16, RGB565 value used by pattern 3.
REQ-012 SHALL have port pclk, output, 1, emulated camera pixel clock.
REQ-013 SHALL have port vsync, output, 1, emulated VSYNC, active high.
REQ-014 SHALL have port href, output, 1, emulated HREF, active high.
REQ-015 SHALL have port data, output, 8, emulated camera byte bus.
REQ-016 SHALL have port frame_start, output, 1, one-clk25 pulse at the start of each frame's VSYNC.
REQ-017 SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-018 pclk SHALL toggle every clk25 cycle after reset, giving 12.5 MHz, free-running whether or not enable is high.
REQ-019 vsync, href and data SHALL change only in the clk25 cycle where pclk goes 1->0, so they are stable at every pclk rising edge.
REQ-020 Each pixel SHALL be 2 pclk periods: high byte [15:8] first, then low byte [7:0]; one line = 2*H_TOTAL pclk periods.
REQ-021 State machine SHALL have states IDLE, SYNC, BACK, ACTIVE and FRONT.
- IDLE->SYNC: on a pclk falling edge with enable=1.
- SYNC: lasts V_SYNC lines with vsync=1.
- BACK: lasts V_BACK lines.
- ACTIVE: lasts V_ACTIVE lines; href=1 for the first 2*H_ACTIVE pclk periods of each line.
- FRONT: lasts V_TOTAL-V_SYNC-V_BACK-V_ACTIVE lines.
- FRONT end: go to SYNC if enable=1, else IDLE.
REQ-022 enable deasserting mid-frame SHALL NOT truncate the frame; the generator completes FRONT, then enters IDLE.
REQ-023 pattern_sel and solid_rgb SHALL be sampled once per frame, on entry to SYNC; changes mid-frame SHALL take effect on the next frame.
REQ-024 Colour bars SHALL be 8 bars of H_ACTIVE/8 pixels: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-025 Gradient SHALL be R=x[9:5], G=x[9:4], B=x[9:5], where x is the active pixel index; x wraps within 10 bits.
REQ-026 Checkerboard SHALL be 32x32 squares: FFFF where x[5]^y[5]=0, else 0000.
REQ-027 data SHALL be 0x00 whenever href=0.
REQ-028 busy SHALL be 1 in every state except IDLE; frame_start SHALL be high exactly one clk25 cycle on entry to SYNC.
REQ-029 The line counter SHALL be 10 bits and the pixel counter 10 bits; both SHALL wrap to 0 at V_TOTAL and H_TOTAL respectively.

Reset
REQ-030 Asynchronous reset SHALL force pclk=0, vsync=0, href=0, data=0x00, frame_start=0, busy=0, state IDLE and all counters to 0.
REQ-031 Reset asserted mid-frame SHALL abort immediately; after release, a new frame SHALL start from SYNC only.

Configuration
REQ-032 With macro OV_STREAM_GEN_SCROLL_EN defined, an 8-bit frame counter SHALL increment at every frame_start.
- Patterns 0 to 2 SHALL use (x + counter) mod H_ACTIVE in place of x, giving one pixel of horizontal scroll per frame.
- Without the macro, there SHALL be no counter and the patterns SHALL be static.

Structure
REQ-033 Package ov_stream_pkg SHALL hold the state enum, the pattern_sel encodings and the 8-entry colour-bar RGB565 table.
REQ-034 Pixel colour generation SHALL be a sub-module, ov_pattern_rgb565 (inputs x, y, pattern, solid; registered 16-bit output), aligned with the byte sequencer.

Verification
REQ-035 Hold enable=1 from reset -> first frame_start occurs within 2 clk25 cycles of reset release; frame_start period = 1,599,360 clk25 cycles.
REQ-036 Measure the first frame -> vsync high for 9408 clk25 cycles; first href rises 20 lines (62,720 clk25) after vsync rises; each href high pulse lasts 2560 clk25; exactly 480 href pulses per frame.
REQ-037 Select pattern 0 and sample data on pclk rising edges -> line bytes begin FF,FF and bytes 160-161 (pixel 80) read FF,E0.
REQ-038 Select pattern 3 with solid_rgb=0xF81F -> every href byte pair reads F8,1F; data=0x00 during horizontal blank.
REQ-039 Drop enable during active line 100 -> the frame completes all 510 lines, busy falls, and no further vsync appears.
REQ-040 Assert reset at line 250 -> all outputs are 0 in the same cycle; after release with enable=1, streaming restarts with vsync high.
